// File: rtl/rr_pipe_arbiter_if.sv
// Handshake bundle for rr_pipe_arbiter: N upstream valid/ready/data channels
// plus the single registered downstream channel and its grant index.
interface rr_pipe_arbiter_if #(
  parameter int L  = 8,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]   valid_f;
  logic [N*L-1:0] data_f;
  logic [N-1:0]   ready_f;
  logic           valid_b;
  logic [L-1:0]   data_b;
  logic [IW-1:0]  grant_id;
  logic           ready_b;

  // slave: the arbiter's view; master: the environment driving it
  modport slave (
    input  valid_f, data_f, ready_b,
    output ready_f, valid_b, data_b, grant_id
  );
  modport master (
    output valid_f, data_f, ready_b,
    input  ready_f, valid_b, data_b, grant_id
  );
endinterface

// File: rtl/rr_pipe_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output slot.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority (no rotating pointer).
module rr_pipe_arbiter #(
  parameter int L  = 8,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  rr_pipe_arbiter_if.slave bus
);

  logic          valid_reg;
  logic [L-1:0]  data_reg;
  logic [IW-1:0] grant_reg;

  logic          accept;
  logic          any_valid;
  logic [IW-1:0] sel;
  logic [L-1:0]  sel_data;
  logic [L-1:0]  lane [N];

  assign accept    = ~valid_reg | bus.ready_b;
  assign any_valid = |bus.valid_f;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane[gi] = bus.data_f[gi*L +: L];
    end
  endgenerate

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.valid_f[i]) sel = IW'(i);
    end
  end
`else
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] cand [N];

  // cand[k] is the k-th requester in search order starting at ptr_reg
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IW:0] sum;
      logic [IW:0] wrapped;
      assign sum       = {1'b0, ptr_reg} + (IW+1)'(gi);
      assign wrapped   = sum - (IW+1)'(N);
      assign cand[gi]  = (sum >= (IW+1)'(N)) ? wrapped[IW-1:0] : sum[IW-1:0];
    end
  endgenerate

  // Walk backwards so the earliest candidate in search order wins
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.valid_f[cand[k]]) sel = cand[k];
    end
  end

  assign ptr_next = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else if (accept && any_valid) begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  assign sel_data = lane[sel];

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign bus.ready_f[gi] = accept & any_valid & (sel == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      grant_reg <= '0;
    end else if (accept) begin
      valid_reg <= any_valid;
      if (any_valid) begin
        data_reg  <= sel_data;
        grant_reg <= sel;
      end
    end
  end

  assign bus.valid_b  = valid_reg;
  assign bus.data_b   = data_reg;
  assign bus.grant_id = grant_reg;

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Self-checking bench for rr_pipe_arbiter: directed literal checks plus a
// randomized run compared every cycle against a behavioural slot/pointer model.
module tb_rr_pipe_arbiter;
  localparam int L = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  rr_pipe_arbiter_if #(.L(L), .N(N)) bus ();

  rr_pipe_arbiter #(.L(L), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as it must be after the most recent rising edge
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_grant = 0;
  int         m_ptr   = 0;

  function automatic int model_sel(input logic [N-1:0] vf, input int p);
    int start;
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < N; k++) begin
      if (vf[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Compare process: inputs and state are stable at the falling edge
  always @(negedge clk) begin
    int         s;
    logic       acc;
    logic [3:0] exp_rf;
    if (!rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_grant = 0; m_ptr = 0;
      chk("rst_valid_b", 32'(bus.valid_b), 32'd0);
      chk("rst_data_b",  32'(bus.data_b),  32'd0);
      chk("rst_grant",   32'(bus.grant_id), 32'd0);
    end else begin
      chk("m_valid_b", 32'(bus.valid_b),  32'(m_valid));
      chk("m_data_b",  32'(bus.data_b),   32'(m_data));
      chk("m_grant",   32'(bus.grant_id), 32'(m_grant));
      acc    = !m_valid || bus.ready_b;
      s      = model_sel(bus.valid_f, m_ptr);
      exp_rf = (acc && s >= 0) ? 4'(1 << s) : 4'b0000;
      chk("m_ready_f", 32'(bus.ready_f), 32'(exp_rf));
      if (acc) begin
        if (s >= 0) begin
          m_valid = 1'b1;
          m_data  = bus.data_f[s*L +: L];
          m_grant = s;
          m_ptr   = (s + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] vf, input logic rb);
    @(posedge clk); #1;
    bus.valid_f = vf;
    bus.ready_b = rb;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [3:0] rf;
    bus.valid_f = '0;
    bus.data_f  = 32'hA3A2A1A0;
    bus.ready_b = 1'b1;

    @(negedge clk); @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0000, 1'b1);
      chk("idle_valid_b", 32'(bus.valid_b), 32'd0);
      chk("idle_ready_f", 32'(bus.ready_f), 32'd0);
      chk("idle_data_b",  32'(bus.data_b),  32'd0);
      chk("idle_grant",   32'(bus.grant_id), 32'd0);
    end

`ifndef ARB_FIXED_PRIO_EN
    cyc(4'b1111, 1'b1);
    chk("rr_first_ready_f", 32'(bus.ready_f), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b1);
      chk("rr_seq_grant", 32'(bus.grant_id), 32'(k % 4));
      chk("rr_seq_data",  32'(bus.data_b),   32'(8'hA0 + (k % 4)));
      chk("rr_seq_valid", 32'(bus.valid_b),  32'd1);
    end
    // Edge loads A1; afterwards requester 2 waits behind a stalled slot
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0100, 1'b0);
      chk("stall_data",    32'(bus.data_b),  32'hA1);
      chk("stall_ready_f", 32'(bus.ready_f), 32'h0);
    end
    cyc(4'b0100, 1'b1);
    chk("drain_ready_f", 32'(bus.ready_f), 32'h4);
    chk("drain_data",    32'(bus.data_b),  32'hA1);
    cyc(4'b0000, 1'b1);
    chk("drain_load_data",  32'(bus.data_b),   32'hA2);
    chk("drain_load_grant", 32'(bus.grant_id), 32'd2);
    // ptr is now 3: requests 0 and 1 must wrap to 0 first
    cyc(4'b0011, 1'b1);
    chk("wrap_empty",   32'(bus.valid_b), 32'd0);
    chk("wrap_ready_f", 32'(bus.ready_f), 32'h1);
    cyc(4'b0010, 1'b1);
    chk("wrap_grant0",   32'(bus.grant_id), 32'd0);
    chk("wrap_ready_f1", 32'(bus.ready_f),  32'h2);
    cyc(4'b0000, 1'b1);
    chk("wrap_grant1", 32'(bus.grant_id), 32'd1);
    chk("wrap_data1",  32'(bus.data_b),   32'hA1);

    // Asynchronous reset while the slot is full
    @(posedge clk); #3;
    bus.valid_f = 4'b1010;
    rst = 1'b0;
    #1;
    chk("arst_valid_b", 32'(bus.valid_b),  32'd0);
    chk("arst_grant",   32'(bus.grant_id), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready_f", 32'(bus.ready_f), 32'h2);
    cyc(4'b0000, 1'b1);
    chk("post_rst_grant", 32'(bus.grant_id), 32'd1);
`else
    cyc(4'b1010, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cyc(4'b1010, 1'b1);
      chk("fixed_grant",   32'(bus.grant_id), 32'd1);
      chk("fixed_ready_f", 32'(bus.ready_f),  32'h2);
    end
`endif

    // Randomized run; a requester keeps its word until its ready_f was high
    bus.valid_f = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      rf = bus.ready_f;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!bus.valid_f[i] || rf[i]) begin
          bus.valid_f[i]         = ($urandom_range(0, 2) != 0);
          bus.data_f[i*L +: L]   = 8'($urandom);
        end
      end
      bus.ready_b = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_pipe_arbiter.md
# rr_pipe_arbiter

Round-robin arbiter that shares one valid/ready pipeline stage among N upstream requesters. Each requester presents a valid/ready/data channel. The block selects one per cycle, captures its word into a single registered output slot, and drives a single downstream valid/ready channel. It sits in front of the team's backward-pressure pipe stages, which see it as an ordinary upstream producer.

## Interface
- L, default 8: data width per requester.
- N, default 4: number of requesters, 2..16.
- IW, default $clog2(N): width of the grant index.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_f  in  N  per-requester valid; bit i belongs to requester i.
- data_f  in  N*L  per-requester data; requester i occupies bits [i*L +: L].
- ready_f  out  N  per-requester ready; combinational; at most one bit high.
- valid_b  out  1  downstream valid; registered.
- data_b  out  L  downstream data; registered.
- grant_id  out  IW  index of the requester whose word is in data_b; registered.
- ready_b  in  1  downstream ready.

## Operation
- Output slot states:
  - EMPTY: valid_b=0.
  - FULL: valid_b=1.
- accept = ~valid_b | ready_b. The slot can load this cycle when it is EMPTY, or when it is FULL and draining.
- Arbitration is combinational. sel = the first i with valid_f[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1, with the index wrapping mod N.
- ready_f[sel] = accept & (|valid_f). All other bits of ready_f are 0. No valid requests means ready_f=0.
- On a rising edge with accept=1 and |valid_f=1:
  - valid_b<=1, data_b<=data_f[sel], grant_id<=sel.
  - ptr<=sel+1, wrapping N-1→0.
- On a rising edge with accept=1 and valid_f=0:
  - valid_b<=0.
  - data_b, grant_id and ptr hold.
- On a rising edge with accept=0 (FULL with ready_b=0): all state holds.
- Requesters must hold valid_f and data_f stable until their ready_f is high. The block never drops or duplicates an accepted word.
- A requester that keeps valid_f high waits at most N-1 grants to other requesters before it is served.

## Timing
- Reset values:
  - valid_b=0, data_b=0, grant_id=0, ptr=0.
  - ready_f is 0 for as long as valid_f is 0.
- Latency: a word accepted at edge k appears on data_b/valid_b immediately after edge k.
- Throughput: one word per cycle while ready_b=1.
- Combinational path from ready_b to ready_f. Downstream stages must not derive ready_b combinationally from valid_b.
- Simultaneous drain and load (FULL, ready_b=1, a request pending): the old word transfers and the new word loads on the same edge. There is no bubble.
- Reset asserted mid-transfer: the slot is cleared immediately (asynchronously) and the pending word is discarded. ptr returns to 0.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. sel = the lowest index with valid_f set. ptr is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then valid_f=4'b0000 for 3 cycles -> valid_b=0, ready_f=0, data_b=0, grant_id=0 throughout.
- valid_f=4'b1111 held, data_f[i]=8'hA0+i, ready_b=1 -> grant_id sequence 0,1,2,3,0 on consecutive cycles, with data_b = A0,A1,A2,A3,A0.
- Slot FULL with 8'hA1, ready_b=0 for 4 cycles, valid_f=4'b0100 -> ready_f=0, data_b holds A1. Then ready_b=1 -> ready_f=4'b0100 that cycle and data_b=A2 on the next edge.
- ptr=3, valid_f=4'b0011 -> grant 0 first (wrap-around), then 1.
- rst pulsed low while valid_b=1 -> valid_b=0 at once; the first grant after release goes to the lowest active index.
- With ARB_FIXED_PRIO_EN defined, valid_f=4'b1010 held, ready_b=1 -> grant_id=1 on every cycle; requester 3 is never served.
